// File: rtl/eceg_decryptor.sv
// EC-ElGamal decryption M = C2 - d*C1 over GF(PRIME), sharing one curve
// arithmetic unit between the scalar multiply and the final point add.
`timescale 1ns/1ps
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif
`ifndef P
`define P 17
`endif

// state    | meaning
// IDLE     | waiting for start
// DRAIN    | sub-unit may still run from before a reset; wait for its ready
// MUL_GO   | launch S = d*C1
// MUL_WAIT | wait for S
// NEG      | S := -S, detect C2 == S (infinite sum)
// ADD_GO   | launch C2 + (-S)
// ADD_WAIT | wait for M
// FIN      | done pulse
module eceg_decryptor #(
    parameter int DATAWIDTH = `DATAWIDTH,
    parameter int PRIME     = `P
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] d,
    input  logic [DATAWIDTH-1:0] c1x,
    input  logic [DATAWIDTH-1:0] c1y,
    input  logic [DATAWIDTH-1:0] c2x,
    input  logic [DATAWIDTH-1:0] c2y,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DATAWIDTH-1:0] mx,
    output logic [DATAWIDTH-1:0] my
);
    typedef enum logic [2:0] {IDLE, DRAIN, MUL_GO, MUL_WAIT, NEG, ADD_GO, ADD_WAIT, FIN} state_t;
    state_t state, state_next;

    logic [DATAWIDTH-1:0] d_r, c1x_r, c1y_r, c2x_r, c2y_r, sx, sy, sy_neg;
    logic [DATAWIDTH-1:0] u_px, u_py, u_qx, u_qy;
    logic                 s_inf, drain, u_qinf, u_ready, ueca_en, in_wait, qual, s_hits_c2;
    logic [1:0]           wait_cnt;

    assign in_wait   = state inside {DRAIN, MUL_WAIT, ADD_WAIT};
    // the unit's ready may still be stale for two cycles after a launch
    assign qual      = in_wait && (wait_cnt == 2'd2) && u_ready;
    assign sy_neg    = (sy == '0) ? '0 : DATAWIDTH'(PRIME) - sy;
    assign s_hits_c2 = (sx == c2x_r) && (sy_neg != c2y_r);
    assign u_px      = (state == MUL_GO) ? c1x_r : c2x_r;
    assign u_py      = (state == MUL_GO) ? c1y_r : c2y_r;

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == FIN);
        ueca_en    = (state == MUL_GO) || (state == ADD_GO);
        case (state)
            IDLE:     if (start) state_next = drain ? DRAIN : ((d == '0) ? FIN : MUL_GO);
            DRAIN:    if (qual) state_next = (d_r == '0) ? FIN : MUL_GO;
            MUL_GO:   state_next = MUL_WAIT;
            MUL_WAIT: if (qual) state_next = NEG;
            NEG:      state_next = (s_inf || s_hits_c2) ? FIN : ADD_GO;
            ADD_GO:   state_next = ADD_WAIT;
            ADD_WAIT: if (qual) state_next = FIN;
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_r <= '0; c1x_r <= '0; c1y_r <= '0; c2x_r <= '0; c2y_r <= '0;
            sx <= '0; sy <= '0; s_inf <= 1'b0;
            err <= 1'b0; mx <= '0; my <= '0; wait_cnt <= '0;
            // the unit has no reset, so remember it may still be mid-operation
            drain <= (state inside {MUL_WAIT, ADD_WAIT, DRAIN}) || (drain && state == IDLE);
        end else begin
            if (state != state_next)                   wait_cnt <= '0;
            else if (in_wait && wait_cnt != 2'd2)      wait_cnt <= wait_cnt + 2'd1;
            case (state)
                IDLE: if (start) begin
                    d_r <= d; c1x_r <= c1x; c1y_r <= c1y; c2x_r <= c2x; c2y_r <= c2y;
                    err <= 1'b0;
                    if (!drain && d == '0) begin
                        err <= 1'b1; mx <= '0; my <= '0;
                    end
                end
                DRAIN: if (qual) begin
                    drain <= 1'b0;
                    if (d_r == '0) begin
                        err <= 1'b1; mx <= '0; my <= '0;
                    end
                end
                MUL_WAIT: if (qual) begin
                    sx <= u_qx; sy <= u_qy; s_inf <= u_qinf;
                end
                NEG: begin
                    if (s_inf) begin
                        mx <= c2x_r; my <= c2y_r;
                    end else if (s_hits_c2) begin
                        err <= 1'b1; mx <= '0; my <= '0;
                    end else begin
                        sy <= sy_neg;
                    end
                end
                ADD_WAIT: if (qual) begin
                    if (u_qinf) begin
                        err <= 1'b1; mx <= '0; my <= '0;
                    end else begin
                        mx <= u_qx; my <= u_qy;
                    end
                end
                default: ;
            endcase
        end
    end

    UECAUnit #(.DATAWIDTH(DATAWIDTH), .PRIME(PRIME)) u_ueca (
        .clk(clk), .enable(ueca_en), .mode(state == MUL_GO), .k(d_r),
        .Px(u_px), .Py(u_py), .P2x(sx), .P2y(sy),
        .Qx(u_qx), .Qy(u_qy), .qinf(u_qinf), .outReady(u_ready)
    );
endmodule

// Curve y^2 = x^3 + CURVE_A*x + b: mode=1 computes k*P, mode=0 computes P + P2.
// Inverses are found by a linear search, so latency depends on the operands.
module UECAUnit #(
    parameter int DATAWIDTH = `DATAWIDTH,
    parameter int PRIME     = `P,
    parameter int CURVE_A   = 2
) (
    input  logic                 clk,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [DATAWIDTH-1:0] k,
    input  logic [DATAWIDTH-1:0] Px,
    input  logic [DATAWIDTH-1:0] Py,
    input  logic [DATAWIDTH-1:0] P2x,
    input  logic [DATAWIDTH-1:0] P2y,
    output logic [DATAWIDTH-1:0] Qx,
    output logic [DATAWIDTH-1:0] Qy,
    output logic                 qinf,
    output logic                 outReady
);
    localparam int W2 = 2 * DATAWIDTH;
    localparam logic [W2-1:0] PM = W2'(PRIME);
    typedef logic [DATAWIDTH-1:0] elem_t;
    localparam elem_t ONE = elem_t'(1);

    function automatic elem_t fmul(input elem_t a, input elem_t b);
        logic [W2-1:0] t;
        t = W2'(a) * W2'(b);
        return elem_t'(t % PM);
    endfunction
    function automatic elem_t fadd(input elem_t a, input elem_t b);
        logic [W2-1:0] t;
        t = W2'(a) + W2'(b);
        return elem_t'(t % PM);
    endfunction
    function automatic elem_t fsub(input elem_t a, input elem_t b);
        logic [W2-1:0] t;
        t = W2'(a) + PM - W2'(b);
        return elem_t'(t % PM);
    endfunction

    typedef enum logic [2:0] {U_DONE, U_STEP, U_SETUP, U_INV, U_APPLY} ustate_t;
    ustate_t ust;
    logic    is_mul, to_acc, acc_inf, base_inf, ainf, binf, op_done, r_inf;
    elem_t   kreg, acc_x, acc_y, base_x, base_y, ax, ay, bx, by, num, den, tinv, lam;
    elem_t   rx, ry, num_c, den_c, x3, sq;

    assign outReady = (ust == U_DONE);

    always_comb begin
        op_done = 1'b0; r_inf = 1'b0; rx = '0; ry = '0; num_c = '0; den_c = '0;
        sq = fmul(ax, ax);
        x3 = fsub(fsub(fmul(lam, lam), ax), bx);
        if (ust == U_SETUP) begin
            if (ainf) begin
                op_done = 1'b1; rx = bx; ry = by; r_inf = binf;
            end else if (binf) begin
                op_done = 1'b1; rx = ax; ry = ay;
            end else if (ax == bx && (ay != by || ay == '0)) begin
                op_done = 1'b1; r_inf = 1'b1;
            end else if (ax == bx) begin
                num_c = fadd(fadd(sq, sq), fadd(sq, elem_t'(CURVE_A)));
                den_c = fadd(ay, ay);
            end else begin
                num_c = fsub(by, ay);
                den_c = fsub(bx, ax);
            end
        end else if (ust == U_APPLY) begin
            op_done = 1'b1; rx = x3; ry = fsub(fmul(lam, fsub(ax, x3)), ay);
        end
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            is_mul <= mode;
            if (mode) begin
                kreg <= k; acc_inf <= 1'b1; acc_x <= '0; acc_y <= '0;
                base_x <= Px; base_y <= Py; base_inf <= 1'b0; ust <= U_STEP;
            end else begin
                ax <= Px; ay <= Py; ainf <= 1'b0;
                bx <= P2x; by <= P2y; binf <= 1'b0; ust <= U_SETUP;
            end
        end else begin
            case (ust)
                U_STEP: begin
                    if (kreg == '0) begin
                        Qx <= acc_x; Qy <= acc_y; qinf <= acc_inf; ust <= U_DONE;
                    end else begin
                        // low bit set: acc += base, else base doubles and k shifts
                        if (kreg[0]) begin
                            ax <= acc_x; ay <= acc_y; ainf <= acc_inf; to_acc <= 1'b1; kreg[0] <= 1'b0;
                        end else begin
                            ax <= base_x; ay <= base_y; ainf <= base_inf; to_acc <= 1'b0; kreg <= kreg >> 1;
                        end
                        bx <= base_x; by <= base_y; binf <= base_inf; ust <= U_SETUP;
                    end
                end
                U_SETUP: if (!op_done) begin
                    num <= num_c; den <= den_c; tinv <= ONE; ust <= U_INV;
                end
                U_INV: begin
                    if (fmul(den, tinv) == ONE) begin
                        lam <= fmul(num, tinv); ust <= U_APPLY;
                    end else begin
                        tinv <= tinv + ONE;
                    end
                end
                default: ;
            endcase
            if (op_done) begin
                if (!is_mul) begin
                    Qx <= rx; Qy <= ry; qinf <= r_inf; ust <= U_DONE;
                end else if (to_acc) begin
                    acc_x <= rx; acc_y <= ry; acc_inf <= r_inf; ust <= U_STEP;
                end else begin
                    base_x <= rx; base_y <= ry; base_inf <= r_inf; ust <= U_STEP;
                end
            end
        end
    end
endmodule

// File: tb/tb_eceg_decryptor.sv
// Directed bench for eceg_decryptor on the PRIME=17 curve y^2 = x^3 + 2x + 2, G = (5,1).
`timescale 1ns/1ps
module tb_eceg_decryptor;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] d = '0, c1x = '0, c1y = '0, c2x = '0, c2y = '0;
    logic         busy, done, err;
    logic [W-1:0] mx, my;

    int vectors = 0, miscompares = 0;
    int done_cnt = 0, en_cnt = 0;
    int d0, e0, cyc;

    eceg_decryptor #(.DATAWIDTH(W), .PRIME(17)) dut (
        .clk(clk), .rst(rst), .start(start), .d(d),
        .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
        .busy(busy), .done(done), .err(err), .mx(mx), .my(my)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (dut.ueca_en) en_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [W-1:0] kd, input logic [W-1:0] ax, input logic [W-1:0] ay,
                         input logic [W-1:0] bx, input logic [W-1:0] by);
        d = kd; c1x = ax; c1y = ay; c2x = bx; c2y = by;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        cyc = 1;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, int'(done), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_mx", mx, 0);
        check("reset_my", my, 0);

        // nominal: 7*(10,6) = (6,3); (16,13) - (6,3) = (3,1)
        e0 = en_cnt; d0 = done_cnt;
        pulse(7, 10, 6, 16, 13);
        check("nom_busy", busy, 1);
        wait_done("nom");
        check("nom_err", err, 0);
        check("nom_mx", mx, 3);
        check("nom_my", my, 1);
        @(negedge clk);
        check("nom_done_once", done_cnt - d0, 1);
        check("nom_enables", en_cnt - e0, 2);
        check("nom_busy_after", busy, 0);
        check("nom_hold_mx", mx, 3);

        // C2 == S: sum is infinity, add never launched
        repeat (2) @(negedge clk);
        e0 = en_cnt;
        pulse(7, 10, 6, 6, 3);
        wait_done("inf");
        check("inf_err", err, 1);
        check("inf_mx", mx, 0);
        check("inf_my", my, 0);
        @(negedge clk);
        check("inf_enables", en_cnt - e0, 1);

        // C2 == -S: add becomes doubling of (6,14) -> (3,16)
        repeat (2) @(negedge clk);
        pulse(7, 10, 6, 6, 14);
        wait_done("dbl");
        check("dbl_err", err, 0);
        check("dbl_mx", mx, 3);
        check("dbl_my", my, 16);

        // zero key
        repeat (2) @(negedge clk);
        e0 = en_cnt;
        pulse(0, 10, 6, 16, 13);
        wait_done("zero");
        check("zero_within_3", int'(cyc <= 3), 1);
        check("zero_err", err, 1);
        check("zero_mx", mx, 0);
        check("zero_my", my, 0);
        @(negedge clk);
        check("zero_enables", en_cnt - e0, 0);

        // reset while the multiply is in flight, then a fresh request must drain first
        repeat (2) @(negedge clk);
        pulse(7, 10, 6, 16, 13);
        repeat (3) @(negedge clk);
        check("midop_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midop_rst_busy", busy, 0);
        check("midop_rst_err", err, 0);
        check("midop_drain_flag", int'(dut.drain), 1);
        d0 = done_cnt;
        pulse(7, 10, 6, 16, 13);
        wait_done("midop");
        check("midop_err", err, 0);
        check("midop_mx", mx, 3);
        check("midop_my", my, 1);
        repeat (20) @(negedge clk);
        check("midop_done_once", done_cnt - d0, 1);

        // reset in the same cycle as start drops the request
        d0 = done_cnt;
        rst = 1'b1;
        pulse(7, 10, 6, 16, 13);
        rst = 1'b0;
        check("rst_start_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("rst_start_no_done", done_cnt - d0, 0);

        // back-to-back: start during busy ignored, start right after done accepted
        d0 = done_cnt;
        pulse(7, 10, 6, 16, 13);
        @(negedge clk);
        check("b2b_busy", busy, 1);
        pulse(7, 10, 6, 6, 14);
        wait_done("b2b1");
        check("b2b1_mx", mx, 3);
        check("b2b1_my", my, 1);
        @(negedge clk);
        pulse(7, 10, 6, 6, 14);
        check("b2b2_accepted", busy, 1);
        wait_done("b2b2");
        check("b2b2_err", err, 0);
        check("b2b2_mx", mx, 3);
        check("b2b2_my", my, 16);
        repeat (5) @(negedge clk);
        check("b2b_done_count", done_cnt - d0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
